iic_byte_engine: RTL and testbench
==================================

Name: iic_byte_engine

Overview:
- Single-master I2C bit/byte sequencer.
- Sits directly downstream of the AXI-lite register block. It consumes a command (op, tx byte, ack bit) decoded from register write pulses, and returns rx byte, received ack and status for register readback.
- Drives the open-drain SCL/SDA pins (scl_o/scl_t, sda_o/sda_t) that the top level ties to IOBUFs.
- Generates START, repeated START, STOP, byte WRITE and byte READ conditions, paced by a quarter-bit-period timer.

Parameters:
- CLK_DIV, 250, clock cycles per quarter bit period (100 MHz / (4*250) = 100 kHz SCL); must be >= 2, checked by an elaboration assertion.
- DIV_WIDTH, 16, width of the quarter-period counter; must hold CLK_DIV-1.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_op  in  2  00 START, 01 STOP, 10 WRITE, 11 READ.
- cmd_tx_data  in  8  byte for WRITE, sent MSB first.
- cmd_ack  in  1  ack bit the master sends after READ (0 = ACK, 1 = NACK).
- rx_data  out  8  last byte received by READ.
- rx_ack  out  1  ack bit sampled from the slave after WRITE.
- done  out  1  one-cycle pulse at command completion.
- busy  out  1  equals ~cmd_ready.
- bus_owned  out  1  set by START completion, cleared by STOP completion.
- scl_i  in  1  SCL pin sense.
- scl_o  out  1  tied 0.
- scl_t  out  1  1 = release (high), 0 = pull low.
- sda_i  in  1  SDA pin sense.
- sda_o  out  1  tied 0.
- sda_t  out  1  1 = release, 0 = pull low.

Behaviour:
- Reset values: scl_t=1, sda_t=1, cmd_ready=1, busy=0, done=0, bus_owned=0, rx_data=0x00, rx_ack=1. FSM returns to IDLE.
- Reset asserted mid-operation releases both lines on the next edge. The bus is then left in whatever condition results; no STOP is generated.
- Timing unit:
  - Each command is a sequence of quarters Q0..Q3. Each quarter lasts exactly CLK_DIV cycles.
  - Pin outputs for Q0 are registered on the accept edge.
- Completion:
  - The cycle after the last quarter expires, the FSM is back in IDLE with done=1 and cmd_ready=1.
  - START/STOP: accept-to-done = 4*CLK_DIV cycles.
  - WRITE/READ: accept-to-done = 36*CLK_DIV cycles.
- States: IDLE, START, STOP, BIT, DONE.
  - Transitions: IDLE -> {START|STOP|BIT} on accept.
  - START -> DONE after Q3; STOP -> DONE after Q3.
  - BIT repeats for bit index 8 down to 0, then -> DONE.
  - DONE -> IDLE after 1 cycle, with done asserted.
- START (also a repeated START when SCL is low):
  - Q0: SDA release.
  - Q1: SCL release.
  - Q2: SDA low.
  - Q3: SCL low.
- STOP:
  - Q0: SDA low.
  - Q1: SCL release.
  - Q2: SDA release.
  - Q3: hold.
  - End state: SCL and SDA both released.
- Per bit:
  - Q0: set SDA with SCL low.
  - Q1: release SCL.
  - Q2: hold; sample sda_i in the last cycle of Q2.
  - Q3: SCL low.
- WRITE:
  - Bits 8..1 drive cmd_tx_data[7:0] MSB first. A data 1 releases SDA; a data 0 pulls it low.
  - Bit 0 (9th clock): SDA released; sampled value goes to rx_ack.
- READ:
  - Bits 8..1: SDA released; samples shift into rx_data MSB first.
  - Bit 0: SDA driven per cmd_ack.
  - rx_data updates only when the command completes.
- cmd_tx_data and cmd_ack are latched on the accept edge; later input changes are ignored.
- cmd_valid while busy: not accepted and not queued.
- WRITE/READ while bus_owned=0 are still executed; policing this is software's job.
- STOP with bus_owned=0 is still executed and leaves bus_owned=0.
- A START issued while bus_owned=1 is a repeated START; bus_owned stays 1.

Optional Feature:
- Macro: IIC_CLK_STRETCH_EN.
- Defined: in Q1 of any bit and in Q1 of STOP, the quarter counter holds at 0 while scl_i==0 after SCL is released (slave clock stretching). Counting starts on the first cycle scl_i reads 1.
- Not defined: the counter runs regardless of scl_i, and scl_i is unused.

Decomposition:
- Package iic_pkg holds:
  - the cmd_op enum (IIC_OP_START, IIC_OP_STOP, IIC_OP_WRITE, IIC_OP_READ);
  - the FSM state enum;
  - the quarter-index typedef (2 bits);
  - the bit-index typedef (4 bits).
- One sub-module, iic_qtr_timer:
  - Loadable down-counter with a hold input (used for stretching).
  - Outputs qtr_tick (last cycle of a quarter) and a 2-bit quarter index.

Test Plan (CLK_DIV=4 unless stated):
- Reset, then START from idle bus -> SDA falls while SCL high at quarter Q2; SCL low after Q3; done 16 cycles after accept; bus_owned=1.
- WRITE 0xA5, slave pulls SDA low on the 9th clock -> SDA levels at SCL rise are 1,0,1,0,0,1,0,1; rx_ack=0; done 144 cycles after accept.
- READ with slave driving 0x3C, cmd_ack=1 -> rx_data=0x3C; SDA released on the 9th clock; done at 144 cycles.
- STOP after READ -> SDA rises while SCL high; both lines released; bus_owned=0.
- cmd_valid pulsed mid-WRITE -> ignored; exactly one done pulse; resetting at bit 4 -> scl_t=sda_t=1 next cycle, cmd_ready=1, bus_owned=0.
- With IIC_CLK_STRETCH_EN defined, slave holds scl_i low 100 cycles in bit 3 -> WRITE done at 144+100 cycles. Same stimulus without the macro -> done at 144 cycles.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared types for the I2C byte engine: command opcodes, FSM states, counters.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package iic_pkg;

  typedef enum logic [1:0] {
    IIC_OP_START = 2'b00,
    IIC_OP_STOP  = 2'b01,
    IIC_OP_WRITE = 2'b10,
    IIC_OP_READ  = 2'b11
  } iic_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_BIT,
    ST_DONE
  } iic_state_e;

  typedef logic [1:0] qtr_idx_t;
  typedef logic [3:0] bit_idx_t;

  // SDA level the master presents for bit b (8..1 data, 0 = ack slot); 1 = released.
  function automatic logic bit_level(iic_op_e op, logic [7:0] tx, logic ack, bit_idx_t b);
    if (b == 4'd0) begin
      return (op == IIC_OP_WRITE) ? 1'b1 : ack;
    end
    return (op == IIC_OP_WRITE) ? tx[3'(b - 4'd1)] : 1'b1;
  endfunction

endpackage

// File: rtl/iic_qtr_timer.sv
// Quarter-bit-period timer: CLK_DIV cycles per quarter, 2-bit quarter index.
// Latency: qtr_tick asserts in the last cycle of each quarter; load restarts at Q0.
// Backpressure: hold freezes the count (slave clock stretching).
module iic_qtr_timer
  import iic_pkg::*;
#(
  parameter int CLK_DIV   = 250,
  parameter int DIV_WIDTH = 16
) (
  input  logic     S_AXI_ACLK,
  input  logic     S_AXI_ARESETN,
  input  logic     load,
  input  logic     run,
  input  logic     hold,
  output logic     qtr_tick,
  output qtr_idx_t qtr_idx
);

  localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(CLK_DIV - 1);

  logic [DIV_WIDTH-1:0] cnt;

  assign qtr_tick = run && !hold && !load && (cnt == '0);

  // Down-counter per quarter; the quarter index advances (and wraps) on each expiry.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      cnt     <= RELOAD;
      qtr_idx <= 2'd0;
    end else if (load) begin
      cnt     <= RELOAD;
      qtr_idx <= 2'd0;
    end else if (run && !hold) begin
      if (cnt == '0) begin
        cnt     <= RELOAD;
        qtr_idx <= qtr_idx + 2'd1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_byte_engine.sv
// Single-master I2C START/STOP/WRITE/READ sequencer driving open-drain SCL/SDA.
// Latency: START/STOP 4*CLK_DIV, WRITE/READ 36*CLK_DIV cycles accept-to-done.
// Backpressure: cmd_ready only when idle; IIC_CLK_STRETCH_EN lets the slave hold SCL low.
module iic_byte_engine
  import iic_pkg::*;
#(
  parameter int CLK_DIV   = 250,
  parameter int DIV_WIDTH = 16
) (
  input  logic       S_AXI_ACLK,
  input  logic       S_AXI_ARESETN,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_tx_data,
  input  logic       cmd_ack,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       done,
  output logic       busy,
  output logic       bus_owned,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("iic_byte_engine: CLK_DIV must be >= 2");
  end
  if ((CLK_DIV - 1) >= (2 ** DIV_WIDTH)) begin : g_bad_width
    $error("iic_byte_engine: DIV_WIDTH too narrow for CLK_DIV-1");
  end

  iic_state_e state, state_n;
  iic_op_e    op_in, op_l;
  qtr_idx_t   qtr;
  bit_idx_t   bit_idx;
  logic       qtr_tick, tmr_load, tmr_run, tmr_hold, accept;
  logic [7:0] tx_l, rx_sh;
  logic       ack_l;
  logic       scl_r, sda_r, scl_n, sda_n;

  assign op_in   = iic_op_e'(cmd_op);
  assign accept  = cmd_valid & cmd_ready;
  assign busy    = ~cmd_ready;
  assign scl_o   = 1'b0;
  assign sda_o   = 1'b0;
  assign scl_t   = scl_r;
  assign sda_t   = sda_r;
  assign tmr_run = (state == ST_START) || (state == ST_STOP) || (state == ST_BIT);

`ifdef IIC_CLK_STRETCH_EN
  // Slave may keep SCL low after we release it in Q1; time only starts once it is seen high.
  assign tmr_hold = ((state == ST_BIT) || (state == ST_STOP)) && (qtr == 2'd1) && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign tmr_hold     = 1'b0;
`endif

  iic_qtr_timer #(
    .CLK_DIV   (CLK_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .load          (tmr_load),
    .run           (tmr_run),
    .hold          (tmr_hold),
    .qtr_tick      (qtr_tick),
    .qtr_idx       (qtr)
  );

  // Next state and the pin levels for the quarter being entered; DONE behaves as IDLE plus the done pulse.
  always_comb begin
    state_n   = state;
    tmr_load  = 1'b0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    scl_n     = scl_r;
    sda_n     = sda_r;
    case (state)
      ST_IDLE, ST_DONE: begin
        cmd_ready = 1'b1;
        done      = (state == ST_DONE);
        state_n   = ST_IDLE;
        if (cmd_valid) begin
          tmr_load = 1'b1;
          case (op_in)
            IIC_OP_START: begin
              state_n = ST_START;
              sda_n   = 1'b1;
            end
            IIC_OP_STOP: begin
              state_n = ST_STOP;
              sda_n   = 1'b0;
            end
            default: begin
              state_n = ST_BIT;
              scl_n   = 1'b0;
              sda_n   = bit_level(op_in, cmd_tx_data, cmd_ack, 4'd8);
            end
          endcase
        end
      end
      ST_START: begin
        if (qtr_tick) begin
          case (qtr)
            2'd0:    scl_n = 1'b1;
            2'd1:    sda_n = 1'b0;
            2'd2:    scl_n = 1'b0;
            default: state_n = ST_DONE;
          endcase
        end
      end
      ST_STOP: begin
        if (qtr_tick) begin
          case (qtr)
            2'd0:    scl_n = 1'b1;
            2'd1:    sda_n = 1'b1;
            2'd2:    ;
            default: state_n = ST_DONE;
          endcase
        end
      end
      ST_BIT: begin
        if (qtr_tick) begin
          case (qtr)
            2'd0: scl_n = 1'b1;
            2'd1: ;
            2'd2: scl_n = 1'b0;
            default: begin
              if (bit_idx == 4'd0) state_n = ST_DONE;
              else sda_n = bit_level(op_l, tx_l, ack_l, bit_idx_t'(bit_idx - 4'd1));
            end
          endcase
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and pin registers; reset releases both lines immediately without a STOP.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state <= ST_IDLE;
      scl_r <= 1'b1;
      sda_r <= 1'b1;
    end else begin
      state <= state_n;
      scl_r <= scl_n;
      sda_r <= sda_n;
    end
  end

  // Command latch, bit counter, SDA sampling and bus ownership tracking.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      op_l      <= IIC_OP_START;
      tx_l      <= 8'h00;
      ack_l     <= 1'b1;
      bit_idx   <= 4'd0;
      rx_sh     <= 8'h00;
      rx_data   <= 8'h00;
      rx_ack    <= 1'b1;
      bus_owned <= 1'b0;
    end else begin
      if (accept) begin
        op_l    <= op_in;
        tx_l    <= cmd_tx_data;
        ack_l   <= cmd_ack;
        bit_idx <= 4'd8;
      end
      if ((state == ST_BIT) && qtr_tick) begin
        if (qtr == 2'd2) begin
          if (bit_idx != 4'd0) rx_sh <= {rx_sh[6:0], sda_i};
          else if (op_l == IIC_OP_WRITE) rx_ack <= sda_i;
        end
        if (qtr == 2'd3) begin
          if (bit_idx != 4'd0) bit_idx <= bit_idx - 4'd1;
          else if (op_l == IIC_OP_READ) rx_data <= rx_sh;
        end
      end
      if (qtr_tick && (qtr == 2'd3)) begin
        if (state == ST_START) bus_owned <= 1'b1;
        if (state == ST_STOP)  bus_owned <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iic_byte_engine.sv
// Scoreboarded bench for iic_byte_engine with a simple open-drain slave model.
// Latency: checks accept-to-done cycle counts per command.
// Backpressure: exercises busy rejection and slave clock stretching.
module tb_iic_byte_engine;
  import iic_pkg::*;

  localparam int CLK_DIV = 4;
`ifdef IIC_CLK_STRETCH_EN
  localparam int STRETCH_LAT = 244;
`else
  localparam int STRETCH_LAT = 144;
`endif
  localparam int SL_IDLE = 0;
  localparam int SL_WR   = 1;
  localparam int SL_RD   = 2;

  typedef struct {
    int         lat;
    logic [7:0] rxd;
    logic       rxa;
    logic       own;
    logic       sclt;
    logic       sdat;
    int         st;
    int         sp;
    logic       chk;
    logic [8:0] bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_ack, done, busy, bus_owned, rx_ack;
  logic [1:0] cmd_op;
  logic [7:0] cmd_tx_data, rx_data;
  logic       scl_i, scl_o, scl_t, sda_i, sda_o, sda_t;
  logic       slave_scl_low, slave_sda;
  int         sl_mode, sl_base, sl_n;
  logic [7:0] sl_data;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         fall_cnt = 0;
  int         starts_seen = 0;
  int         stops_seen = 0;
  logic [8:0] rise_bits = '0;
  logic       scl_q = 1'b1;
  logic       sda_q = 1'b1;
  exp_t       sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign scl_i = scl_t & ~slave_scl_low;
  assign sda_i = sda_t & slave_sda;

  iic_byte_engine #(.CLK_DIV(CLK_DIV), .DIV_WIDTH(16)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_tx_data   (cmd_tx_data),
    .cmd_ack       (cmd_ack),
    .rx_data       (rx_data),
    .rx_ack        (rx_ack),
    .done          (done),
    .busy          (busy),
    .bus_owned     (bus_owned),
    .scl_i         (scl_i),
    .scl_o         (scl_o),
    .scl_t         (scl_t),
    .sda_i         (sda_i),
    .sda_o         (sda_o),
    .sda_t         (sda_t)
  );

  // Slave SDA: changes only after SCL falls; bit n counts SCL falls since the command was issued.
  always_comb begin
    sl_n      = fall_cnt - sl_base;
    slave_sda = 1'b1;
    if (sl_mode == SL_WR && sl_n == 8) slave_sda = 1'b0;
    if (sl_mode == SL_RD && sl_n < 8)  slave_sda = sl_data[3'(7 - sl_n)];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(int lat, logic [7:0] rxd, logic rxa, logic own, logic sclt,
                              logic sdat, int st, int sp, logic chk, logic [8:0] bits);
    exp_t e;
    e.lat = lat; e.rxd = rxd; e.rxa = rxa; e.own = own; e.sclt = sclt;
    e.sdat = sdat; e.st = st; e.sp = sp; e.chk = chk; e.bits = bits;
    return e;
  endfunction

  // Bus observer and scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (scl_q && scl_i && sda_q && !sda_i) starts_seen++;
    if (scl_q && scl_i && !sda_q && sda_i) stops_seen++;
    if (scl_q && !scl_i) fall_cnt++;
    if (!scl_q && scl_i) rise_bits = {rise_bits[7:0], sda_i};
    scl_q = scl_i;
    sda_q = sda_i;
    if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("latency", cyc - acc_cyc, e.lat);
        check("rx_data", int'(rx_data), int'(e.rxd));
        check("rx_ack", int'(rx_ack), int'(e.rxa));
        check("bus_owned", int'(bus_owned), int'(e.own));
        check("scl_t_end", int'(scl_t), int'(e.sclt));
        check("sda_t_end", int'(sda_t), int'(e.sdat));
        check("ready_at_done", int'(cmd_ready), 1);
        check("start_events", starts_seen, e.st);
        check("stop_events", stops_seen, e.sp);
        if (e.chk) check("sda_at_scl_rise", int'(rise_bits), int'(e.bits));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] tx, input logic ack);
    wait_ready();
    cmd_op      = op;
    cmd_tx_data = tx;
    cmd_ack     = ack;
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_tx_data = ~tx;
    cmd_ack     = ~ack;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_rises(input int k);
    int   r = 0;
    int   n = 0;
    logic p;
    p = scl_t;
    while (r < k && n < 1000) begin
      @(posedge clk); #1;
      if (!p && scl_t) r++;
      p = scl_t;
      n++;
    end
    check("scl_rise_count", r, k);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_tx_data = 8'h00; cmd_ack = 1'b1;
    slave_scl_low = 1'b0; sl_mode = SL_IDLE; sl_base = 0; sl_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_t", int'(scl_t), 1);
    check("rst_sda_t", int'(sda_t), 1);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bus_owned", int'(bus_owned), 0);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_ack", int'(rx_ack), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // START from idle bus
    sb.push_back(mk(16, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 9'h0));
    issue(2'b00, 8'h00, 1'b1);
    check("busy_after_accept", int'(busy), 1);
    wait_drain();

    // WRITE 0xA5, slave ACKs
    sl_mode = SL_WR; sl_base = fall_cnt;
    sb.push_back(mk(144, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 9'h14A));
    issue(2'b10, 8'hA5, 1'b0);
    wait_drain();

    // READ 0x3C, master NACKs
    sl_mode = SL_RD; sl_data = 8'h3C; sl_base = fall_cnt;
    sb.push_back(mk(144, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b1, 9'h079));
    issue(2'b11, 8'h00, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("rx_data_mid_read", int'(rx_data), 0);
    wait_drain();

    // STOP, then a STOP on an unowned idle bus
    sl_mode = SL_IDLE;
    sb.push_back(mk(16, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 9'h0));
    issue(2'b01, 8'h00, 1'b1);
    wait_drain();
    sb.push_back(mk(16, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2, 1'b0, 9'h0));
    issue(2'b01, 8'h00, 1'b1);
    wait_drain();

    // START then repeated START
    sb.push_back(mk(16, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 3, 2, 1'b0, 9'h0));
    issue(2'b00, 8'h00, 1'b1);
    wait_drain();
    sb.push_back(mk(16, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 4, 2, 1'b0, 9'h0));
    issue(2'b00, 8'h00, 1'b1);
    wait_drain();

    // WRITE 0x5A with a rejected cmd_valid pulse in the middle
    sl_mode = SL_WR; sl_base = fall_cnt;
    sb.push_back(mk(144, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 4, 2, 1'b1, 9'h0B4));
    issue(2'b10, 8'h5A, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    check("busy_mid_write", int'(busy), 1);
    cmd_op = 2'b00; cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_drain();
    repeat (20) @(posedge clk);
    #1;

    // WRITE 0x00 interrupted by reset during bit 4 (Q1: SCL high, SDA low)
    sl_mode = SL_IDLE;
    issue(2'b10, 8'h00, 1'b0);
    wait_rises(5);
    check("sda_low_at_bit4", int'(sda_t), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_scl_t", int'(scl_t), 1);
    check("mid_rst_sda_t", int'(sda_t), 1);
    check("mid_rst_cmd_ready", int'(cmd_ready), 1);
    check("mid_rst_bus_owned", int'(bus_owned), 0);
    check("mid_rst_rx_data", int'(rx_data), 0);
    check("mid_rst_rx_ack", int'(rx_ack), 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // WRITE with the slave stretching SCL for 100 cycles in bit 3
    sb.push_back(mk(STRETCH_LAT, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4, 3, 1'b0, 9'h0));
    issue(2'b10, 8'h81, 1'b0);
    wait_rises(5);
    n = 0;
    while (scl_t && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    slave_scl_low = 1'b1;
    n = 0;
    while (!scl_t && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("stretch_release_seen", int'(scl_t), 1);
    repeat (100) @(posedge clk);
    #1;
    slave_scl_low = 1'b0;
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
